bip_control: RTL and testbench

- Fetch/decode control stage for the accumulator CPU; sits directly upstream of the program memory.
- Drives the program-memory address (program counter) and consumes the returned 16-bit instruction word.
- Instruction word: opcode = top 5 bits, operand = low 11 bits.
- Decodes each instruction into datapath and data-RAM control strobes; runs until HLT.

---
 rtl/bip_control_if.sv | 32 +++
 rtl/bip_control.sv | 143 ++++++++++++++
 tb/tb_bip_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_if.sv
// Program-memory and control-strobe bundle for the bip_control fetch/decode stage.
// master = control stage, slave = program memory / datapath side.
interface bip_control_if #(
    parameter int addr_bus  = 11,
    parameter int data_size = 16,
    parameter int cnt_width = 32
);
    logic                   Start;
    logic [data_size-1:0]   Data;
    logic [addr_bus-1:0]    Addr;
    logic [data_size-6:0]   Operand;
    logic                   Ram_Wr;
    logic                   Ram_Rd;
    logic [1:0]             SelA;
    logic                   SelB;
    logic                   Acc_Wr;
    logic                   Alu_Op;
    logic                   Halted;
    logic [cnt_width-1:0]   Cycle_Count;

    modport master (
        input  Start, Data,
        output Addr, Operand, Ram_Wr, Ram_Rd, SelA, SelB,
        output Acc_Wr, Alu_Op, Halted, Cycle_Count
    );

    modport slave (
        output Start, Data,
        input  Addr, Operand, Ram_Wr, Ram_Rd, SelA, SelB,
        input  Acc_Wr, Alu_Op, Halted, Cycle_Count
    );
endinterface

// File: rtl/bip_control.sv
// Fetch/decode control stage of the accumulator CPU: PC, IDLE/RUN/HALT FSM, decode.
// Optional executed-cycle counter enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control #(
    parameter int addr_bus  = 11,
    parameter int data_size = 16,
    parameter int cnt_width = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    bip_control_if.master bus
);
    localparam logic [4:0] OP_HLT  = 5'd0;
    localparam logic [4:0] OP_STO  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;

    localparam logic [addr_bus-1:0] PC_ONE = {{(addr_bus-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [addr_bus-1:0] r_pc;
    logic                r_halted;

    logic [4:0] w_opcode;
    logic       w_run;
    logic       w_ram_wr;
    logic       w_ram_rd;
    logic [1:0] w_sel_a;
    logic       w_sel_b;
    logic       w_acc_wr;
    logic       w_alu_op;

    assign w_opcode = bus.Data[data_size-1 -: 5];
    assign w_run    = (r_state == S_RUN);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_opcode == OP_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= r_pc + PC_ONE;
                    end
                end
                S_HALT: begin
                    if (bus.Start) begin
                        r_state  <= S_RUN;
                        r_pc     <= '0;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Strobes follow Data combinationally, but only while RUN.
    always_comb begin
        w_ram_wr = 1'b0;
        w_ram_rd = 1'b0;
        w_sel_a  = 2'd0;
        w_sel_b  = 1'b0;
        w_acc_wr = 1'b0;
        w_alu_op = 1'b0;
        if (w_run) begin
            case (w_opcode)
                OP_STO: w_ram_wr = 1'b1;
                OP_LD: begin
                    w_ram_rd = 1'b1;
                    w_acc_wr = 1'b1;
                end
                OP_LDI: begin
                    w_sel_a  = 2'd1;
                    w_acc_wr = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    w_ram_rd = 1'b1;
                    w_sel_a  = 2'd2;
                    w_acc_wr = 1'b1;
                    w_alu_op = (w_opcode == OP_SUB);
                end
                OP_ADDI, OP_SUBI: begin
                    w_sel_b  = 1'b1;
                    w_sel_a  = 2'd2;
                    w_acc_wr = 1'b1;
                    w_alu_op = (w_opcode == OP_SUBI);
                end
                default: ;
            endcase
        end
    end

    assign bus.Addr    = r_pc;
    assign bus.Operand = bus.Data[data_size-6:0];
    assign bus.Ram_Wr  = w_ram_wr;
    assign bus.Ram_Rd  = w_ram_rd;
    assign bus.SelA    = w_sel_a;
    assign bus.SelB    = w_sel_b;
    assign bus.Acc_Wr  = w_acc_wr;
    assign bus.Alu_Op  = w_alu_op;
    assign bus.Halted  = r_halted;

`ifdef BIP_CYCLE_COUNT_EN
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [cnt_width-1:0] r_cycles;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cycles <= '0;
        end else if (w_run) begin
            r_cycles <= r_cycles + CNT_ONE;
        end else if ((r_state == S_HALT) && bus.Start) begin
            r_cycles <= '0;
        end
    end

    assign bus.Cycle_Count = r_cycles;
`else
    assign bus.Cycle_Count = {cnt_width{1'b0}};
`endif
endmodule

// File: tb/tb_bip_control.sv
// Randomized self-checking bench for bip_control against a behavioural CPU-control model.
// Checks every cycle: Addr, decoded strobes, Operand, Halted, Cycle_Count.
module tb_bip_control;
    logic Clock;
    logic Reset;

    bip_control_if #(.addr_bus(11), .data_size(16), .cnt_width(32)) bus ();

    bip_control #(.addr_bus(11), .data_size(16), .cnt_width(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:2047];
    assign bus.Data = mem[bus.Addr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks;
    int n_pass;

    bit          m_run;
    bit          m_halt;
    logic [10:0] m_pc;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] ins(input int op, input int opr);
        logic [4:0]  o;
        logic [10:0] d;
        o = op[4:0];
        d = opr[10:0];
        return {o, d};
    endfunction

    // {Ram_Wr, Ram_Rd, SelA[1:0], SelB, Acc_Wr, Alu_Op}
    function automatic logic [6:0] exp_strobes(input bit run, input logic [15:0] w);
        int         op;
        logic       wr, rd, sb, acc, alu;
        logic [1:0] sa;
        op = int'(w[15:11]);
        if (!run) return 7'd0;
        wr  = (op == 1);
        rd  = (op == 2) || (op == 4) || (op == 6);
        sa  = (op == 3) ? 2'd1 : ((op >= 4 && op <= 7) ? 2'd2 : 2'd0);
        sb  = (op == 5) || (op == 7);
        acc = (op >= 2) && (op <= 7);
        alu = (op == 6) || (op == 7);
        return {wr, rd, sa, sb, acc, alu};
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef BIP_CYCLE_COUNT_EN
        return m_count;
`else
        return 32'd0;
`endif
    endfunction

    task automatic compare(input string tag);
        logic [15:0] w;
        w = mem[m_pc];
        chk({tag, ".addr"}, 64'(bus.Addr), 64'(m_pc));
        chk({tag, ".strb"}, 64'({bus.Ram_Wr, bus.Ram_Rd, bus.SelA, bus.SelB,
                                 bus.Acc_Wr, bus.Alu_Op}),
            64'(exp_strobes(m_run, w)));
        chk({tag, ".opnd"}, 64'(bus.Operand), 64'(w[10:0]));
        chk({tag, ".halt"}, 64'(bus.Halted), 64'(m_halt));
        chk({tag, ".cnt"}, 64'(bus.Cycle_Count), 64'(exp_cnt()));
    endtask

    task automatic model_step(input bit start);
        logic [15:0] w;
        w = mem[m_pc];
        if (m_run) begin
            m_count = m_count + 32'd1;
            if (w[15:11] == 5'd0) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_pc = m_pc + 11'd1;
            end
        end else if (start) begin
            if (m_halt) begin
                m_pc    = '0;
                m_count = '0;
                m_halt  = 1'b0;
            end
            m_run = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_halt  = 1'b0;
        m_pc    = '0;
        m_count = '0;
    endtask

    task automatic cycle(input string tag, input bit start);
        bus.Start = start;
        @(negedge Clock);
        compare(tag);
        @(posedge Clock);
        model_step(start);
        #1;
        bus.Start = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; returns before the falling edge.
    task automatic async_reset(input string tag);
        #1 Reset = 1'b1;
        model_reset();
        #1 compare(tag);
        #1 Reset = 1'b0;
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 2048; i++) begin
            case (kind)
                0: mem[i] = 16'h0000;
                1: mem[i] = ins($urandom_range(8, 31), $urandom_range(0, 2047));
                default: mem[i] = ins(($urandom_range(0, 15) == 0) ? 0
                                      : $urandom_range(1, 31),
                                      $urandom_range(0, 2047));
            endcase
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        fill(0);
        model_reset();
        repeat (2) @(posedge Clock);
        #1 compare("reset");
        Reset = 1'b0;

        mem[0] = ins(3, 16);
        mem[1] = ins(1, 1);
        mem[2] = ins(2, 1);
        mem[3] = ins(5, 255);
        mem[4] = ins(1, 2);
        mem[5] = ins(2, 16);
        mem[6] = ins(0, 0);
        repeat (2) cycle("idle", 1'b0);
        cycle("start", 1'b1);
        repeat (7) cycle("prog1", 1'b0);
        repeat (3) cycle("halted", 1'b0);
        chk("p1.addr_hold", 64'(bus.Addr), 64'd6);
        chk("p1.halted", 64'(bus.Halted), 64'd1);

        cycle("restart", 1'b1);
        chk("rs.addr0", 64'(bus.Addr), 64'd0);
        chk("rs.unhalt", 64'(bus.Halted), 64'd0);
        repeat (3) cycle("rerun", 1'b0);
        chk("mid.addr3", 64'(bus.Addr), 64'd3);
        async_reset("midrst");
        repeat (3) cycle("postrst", 1'b0);
        chk("postrst.addr", 64'(bus.Addr), 64'd0);
        cycle("resume", 1'b1);
        repeat (10) cycle("resume", 1'b0);

        fill(0);
        mem[0] = ins(9, 1234);
        mem[1] = ins(6, 3);
        mem[2] = ins(7, 5);
        async_reset("p2rst");
        cycle("p2start", 1'b1);
        repeat (6) cycle("prog2", 1'b0);

        fill(1);
        async_reset("wraprst");
        cycle("wrapstart", 1'b1);
        repeat (2100) cycle("wrap", $urandom_range(0, 3) == 0);
        chk("wrap.nohalt", 64'(bus.Halted), 64'd0);

        for (int r = 0; r < 3; r++) begin
            fill(2);
            async_reset("rndrst");
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 60) == 0) async_reset("rndmid");
                cycle("rnd", $urandom_range(0, 4) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
